// File: rtl/tri_bus_drive_seq.sv
// Round-robin sequencer for two bufif0 drivers that share one net. It keeps an all-off
// turnaround window between owners and preempts an owner that exceeds its hold limit.
module tri_bus_drive_seq #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TURN     = 2,
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] in0,
    output logic             ctrl0,
    output logic [WIDTH-1:0] in1,
    output logic             ctrl1,
    output logic             busy
);

    localparam int unsigned HW = $clog2(HOLD_MAX + 1);
    localparam int unsigned TW = $clog2(TURN + 1);
    localparam logic [HW-1:0] HOLD_LIM  = HW'(HOLD_MAX);
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURN - 1);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StTurn} state_t;

    state_t           r_state, w_state_d;
    logic             r_last, w_last_d;
    logic [HW-1:0]    r_hold, w_hold_d;
    logic [TW-1:0]    r_turn, w_turn_d;
    logic             r_gnt0, r_gnt1, r_ctrl0, r_ctrl1, r_busy;
    logic [WIDTH-1:0] r_in0, r_in1, w_in0_d, w_in1_d;
    logic             w_arb, w_arb_any, w_arb_sel;

    // On a tie the requester that did not own the bus last wins.
    assign w_arb_any = req0 | req1;
    assign w_arb_sel = (req0 & req1) ? ~r_last : req1;

    always_comb begin
        w_state_d = r_state;
        w_last_d  = r_last;
        w_hold_d  = r_hold;
        w_turn_d  = r_turn;
        w_in0_d   = r_in0;
        w_in1_d   = r_in1;
        w_arb     = 1'b0;
        unique case (r_state)
            StIdle: w_arb = 1'b1;
            StOwn0: begin
                if (!req0 || (r_hold == HOLD_LIM && req1)) begin
                    w_state_d = StTurn;
                    w_in0_d   = '0;
                    w_turn_d  = TURN_LOAD;
                end else begin
                    w_in0_d = data0;
                    if (r_hold != HOLD_LIM) w_hold_d = r_hold + HW'(1);
                end
            end
            StOwn1: begin
                if (!req1 || (r_hold == HOLD_LIM && req0)) begin
                    w_state_d = StTurn;
                    w_in1_d   = '0;
                    w_turn_d  = TURN_LOAD;
                end else begin
                    w_in1_d = data1;
                    if (r_hold != HOLD_LIM) w_hold_d = r_hold + HW'(1);
                end
            end
            StTurn: begin
                if (r_turn == '0) w_arb = 1'b1;
                else              w_turn_d = r_turn - TW'(1);
            end
            default: w_state_d = StIdle;
        endcase
        if (w_arb) begin
            if (w_arb_any) begin
                w_state_d = w_arb_sel ? StOwn1 : StOwn0;
                w_last_d  = w_arb_sel;
                w_hold_d  = HW'(1);
            end else begin
                w_state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_last  <= 1'b1;
            r_hold  <= '0;
            r_turn  <= '0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_ctrl0 <= 1'b1;
            r_ctrl1 <= 1'b1;
            r_in0   <= '0;
            r_in1   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_last  <= w_last_d;
            r_hold  <= w_hold_d;
            r_turn  <= w_turn_d;
            r_gnt0  <= (w_state_d == StOwn0);
            r_gnt1  <= (w_state_d == StOwn1);
            r_ctrl0 <= (w_state_d != StOwn0);
            r_ctrl1 <= (w_state_d != StOwn1);
            r_in0   <= w_in0_d;
            r_in1   <= w_in1_d;
            r_busy  <= (w_state_d != StIdle);
        end
    end

    assign gnt0  = r_gnt0;
    assign gnt1  = r_gnt1;
    assign ctrl0 = r_ctrl0;
    assign ctrl1 = r_ctrl1;
    assign in0   = r_in0;
    assign in1   = r_in1;
    assign busy  = r_busy;

endmodule

// File: doc/tri_bus_drive_seq.md
Name: tri_bus_drive_seq

Overview:
- Sequencer sitting directly upstream of a pair of bufif0 tri-state drivers that share one output net.
- Arbitrates two requesters and produces each driver's data input and active-low enable (ctrl).
- Enforces a programmable all-off turnaround window between owners, so driver turn-off delay can never overlap the next driver's turn-on (no net contention).
- Round-robin arbitration, plus a hold limit that preempts a long-running owner.

Parameters:
WIDTH, 8, data width per driver.
TURN, 2, cycles with both ctrl high between owner changes; legal range >= 1.
HOLD_MAX, 16, max owned cycles before preemption when the other side is requesting; legal range >= 1.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req0  input  1  requester 0 wants the bus; level, held while it wants ownership.
data0  input  WIDTH  requester 0 data.
req1  input  1  requester 1 wants the bus.
data1  input  WIDTH  requester 1 data.
gnt0  output  1  requester 0 owns the bus.
gnt1  output  1  requester 1 owns the bus.
in0  output  WIDTH  data to driver 0.
ctrl0  output  1  driver 0 enable, active-low (bufif0 control).
in1  output  WIDTH  data to driver 1.
ctrl1  output  1  driver 1 enable, active-low.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- All outputs are registered.
- Reset values (asserted asynchronously, held while rst=1):
  - ctrl0=ctrl1=1, gnt0=gnt1=0, in0=in1=0, busy=0.
  - state=IDLE, rr pointer last=1 (requester 0 wins the first tie), hold counter=0, turn counter=0.
- States: IDLE, OWN0, OWN1, TURN.
- Arbitration at edge k (evaluated in IDLE, or in TURN once the turn counter expires):
  - Only one request: grant that requester.
  - Both requesting: grant the requester != last.
  - Neither requesting: go to or stay in IDLE.
- Entering OWNx after edge k:
  - gntx=1, ctrlx=0.
  - last<=x, hold counter<=1.
- In OWNx, at every edge:
  - inx<=datax, so data has one-cycle latency.
  - The non-owner's in stays 0 and its ctrl stays 1.
- Leaving OWNx to TURN at edge k, when either:
  - reqx sampled 0; or
  - hold counter==HOLD_MAX and the other req is sampled 1 (preemption).
  - At that edge: gntx=0, ctrlx=1, inx<=0, turn counter<=TURN-1.
- Staying in OWNx:
  - Hold counter increments and saturates at HOLD_MAX.
  - With no competing request the owner stays indefinitely.
- TURN:
  - Both ctrl=1, both gnt=0, busy=1.
  - Counter decrements each edge; arbitration runs at the edge where counter==0.
  - Next owner's ctrl falls after edge k+TURN, where k is the leaving edge. This gives exactly TURN full cycles with both drivers off.
  - If nobody is requesting at expiry, go to IDLE.
- The preempted owner may keep req high. It re-wins after the other owner finishes, via round-robin.
- Invariant: ctrl0 and ctrl1 are never simultaneously 0; gntx==~ctrlx at all times.
- IDLE to OWN has no turnaround, because the bus is already off.
- Reset mid-operation: outputs return to reset values immediately, without waiting for a clock edge. After rst deasserts, the first grant follows normal IDLE arbitration.
- Counter widths: hold counter is $clog2(HOLD_MAX+1) bits; turn counter is $clog2(TURN+1) bits. No wrap-around is permitted.

Test Plan:
1. Reset: assert rst mid-cycle with no clock -> ctrl0=ctrl1=1, gnt0=gnt1=0, in0=in1=0, busy=0 immediately.
2. Single owner: req0=1, data0=8'hA5 sampled at edge 1 -> after edge 1 gnt0=1, ctrl0=0. After edge 2 in0=8'hA5. in1=0, ctrl1=1 throughout.
3. Handoff, TURN=2: OWN0 with req1=1 pending, req0 dropped at edge 10 -> after edge 10 ctrl0=1. Both ctrl high after edges 10 and 11. After edge 12 ctrl1=0, gnt1=1.
4. Tie from IDLE: after reset, req0=req1=1 at same edge -> gnt0 first. After req0 drops and TURN elapses, gnt1. A second simultaneous tie from IDLE (last=1) -> gnt0.
5. Preemption, HOLD_MAX=4: req0 held constantly, req1 asserted from the grant cycle -> ctrl0 rises after the 4th owned cycle. ctrl1 falls TURN cycles later. gnt0 returns after req1 drops and the turnaround completes.
6. Reset during OWN1 and during TURN -> ctrl1 rises asynchronously, state IDLE. The next req1 grant occurs one edge after rst release, with no turnaround.
